// File: rtl/rr_arb_pkg.sv
// Shared types and width helpers for the N-way round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    KEEP,
    ARB,
    IDLE
  } rr_decision_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: first set bit of req scanning start, start+1, ... with wrap.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] rot;

  // Doubling the vector turns the wrap-around scan into a plain low-to-high search.
  always_comb begin
    rot   = N'({req, req} >> start);
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = IW'((32'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered requests, one-hot registered grant
// and bounded grant locking of up to HOLD_MAX consecutive cycles.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD_MAX = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         ir,
  input  logic [N-1:0]         il,
  output logic [N-1:0]         ack,
  output logic [idx_w(N)-1:0]  ack_id,
  output logic                 ack_valid
);

  localparam int unsigned IW = idx_w(N);
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  logic [N-1:0]  req_q, lock_q;
  logic [N-1:0]  ack_q, ack_d;
  logic [IW-1:0] ack_id_q, ack_id_d;
  logic          ack_valid_q, ack_valid_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  rr_decision_e  decision;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req_q),
    .start (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    ack_d       = ack_q;
    ack_id_d    = ack_id_q;
    ack_valid_d = ack_valid_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;

    if (ack_valid_q && req_q[ack_id_q] && lock_q[ack_id_q] && (hold_q < HW'(HOLD_MAX)))
      decision = KEEP;
    else if (pick_found)
      decision = ARB;
    else
      decision = IDLE;

    // ptr already points past the holder, so an expired holder is scanned last.
    case (decision)
      KEEP: hold_d = hold_q + HW'(1);
      ARB: begin
        ack_d           = '0;
        ack_d[pick_idx] = 1'b1;
        ack_id_d        = pick_idx;
        ack_valid_d     = 1'b1;
        ptr_d           = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
        hold_d          = HW'(1);
      end
      default: begin
        ack_d       = '0;
        ack_id_d    = '0;
        ack_valid_d = 1'b0;
        hold_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q       <= '0;
      lock_q      <= '0;
      ack_q       <= '0;
      ack_id_q    <= '0;
      ack_valid_q <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      req_q       <= ir;
      lock_q      <= il;
      ack_q       <= ack_d;
      ack_id_q    <= ack_id_d;
      ack_valid_q <= ack_valid_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign ack       = ack_q;
  assign ack_id    = ack_id_q;
  assign ack_valid = ack_valid_q;

  a_ack_onehot0: assert property (@(posedge clock) $onehot0(ack_q));
  a_ack_valid:   assert property (@(posedge clock) ack_valid_q == (|ack_q));
  a_grant_req:   assert property (@(posedge clock) disable iff (reset)
                                  (ack_q & ~$past(req_q)) == '0);

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n (N=4, HOLD_MAX=3) with hand-computed grants.
module tb_rr_arbiter_n;

  logic       clock;
  logic       reset;
  logic [3:0] ir;
  logic [3:0] il;
  logic [3:0] ack;
  logic [1:0] ack_id;
  logic       ack_valid;

  int n_assert;
  int n_fail;

  rr_arbiter_n #(
    .N        (4),
    .HOLD_MAX (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ir        (ir),
    .il        (il),
    .ack       (ack),
    .ack_id    (ack_id),
    .ack_valid (ack_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ack(input string tag, input logic [3:0] exp_ack, input logic [1:0] exp_id);
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "_id"}, 32'(ack_id), 32'(exp_id));
    chk({tag, "_valid"}, 32'(ack_valid), 32'(exp_ack != 4'b0000));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset held for two edges with all requesting
    reset = 1'b1;
    ir    = 4'b1111;
    il    = 4'b0000;
    step();
    step();
    chk_ack("rst", 4'b0000, 2'd0);
    chk("rst_ptr", 32'(dut.ptr_q), 32'd0);
    chk("rst_hold", 32'(dut.hold_q), 32'd0);
    reset = 1'b0;

    step();
    chk("rel_req", 32'(dut.req_q), 32'hF);
    chk_ack("rel0", 4'b0000, 2'd0);

    // Full rotation
    step(); chk_ack("rot0", 4'b0001, 2'd0);
    step(); chk_ack("rot1", 4'b0010, 2'd1);
    step(); chk_ack("rot2", 4'b0100, 2'd2);
    step(); chk_ack("rot3", 4'b1000, 2'd3);
    step(); chk_ack("rot4", 4'b0001, 2'd0);

    // Sole requester 2 (first edge still arbitrates the old 1111 from ptr 1)
    ir = 4'b0100;
    step(); chk_ack("sole_t", 4'b0010, 2'd1);
    step(); chk_ack("sole0", 4'b0100, 2'd2);
    chk("sole0_ptr", 32'(dut.ptr_q), 32'd3);
    step(); chk_ack("sole1", 4'b0100, 2'd2);
    chk("sole1_ptr", 32'(dut.ptr_q), 32'd3);

    // Bounded lock: requester 0 locked, requester 1 competing
    ir = 4'b0011;
    il = 4'b0001;
    step(); chk_ack("lock_t", 4'b0100, 2'd2);
    step(); chk_ack("lock0", 4'b0001, 2'd0);
    chk("lock0_hold", 32'(dut.hold_q), 32'd1);
    step(); chk_ack("lock1", 4'b0001, 2'd0);
    step(); chk_ack("lock2", 4'b0001, 2'd0);
    chk("lock2_hold", 32'(dut.hold_q), 32'd3);
    step(); chk_ack("lock3", 4'b0010, 2'd1);
    step(); chk_ack("lock4", 4'b0001, 2'd0);
    step(); chk_ack("lock5", 4'b0001, 2'd0);
    step(); chk_ack("lock6", 4'b0001, 2'd0);
    step(); chk_ack("lock7", 4'b0010, 2'd1);

    // Idle gap with pointer retention
    ir = 4'b0010;
    il = 4'b0000;
    step(); chk_ack("gap_t", 4'b0001, 2'd0);
    step(); chk_ack("gap_g1", 4'b0010, 2'd1);
    ir = 4'b0000;
    step(); chk_ack("gap_g1b", 4'b0010, 2'd1);
    step(); chk_ack("gap0", 4'b0000, 2'd0);
    chk("gap0_hold", 32'(dut.hold_q), 32'd0);
    ir = 4'b1111;
    step(); chk_ack("gap1", 4'b0000, 2'd0);
    chk("gap1_ptr", 32'(dut.ptr_q), 32'd2);
    step(); chk_ack("gap_first", 4'b0100, 2'd2);
    chk("gap_first_ptr", 32'(dut.ptr_q), 32'd3);

    // Reset while requester 0 is locked at hold count 2
    ir = 4'b0001;
    il = 4'b0001;
    step(); chk_ack("ml_t", 4'b1000, 2'd3);
    step(); chk_ack("ml0", 4'b0001, 2'd0);
    step(); chk_ack("ml1", 4'b0001, 2'd0);
    chk("ml1_hold", 32'(dut.hold_q), 32'd2);
    reset = 1'b1;
    step(); chk_ack("ml_rst", 4'b0000, 2'd0);
    chk("ml_rst_ptr", 32'(dut.ptr_q), 32'd0);
    chk("ml_rst_hold", 32'(dut.hold_q), 32'd0);
    chk("ml_rst_req", 32'(dut.req_q), 32'd0);
    reset = 1'b0;
    ir = 4'b0011;
    il = 4'b0000;
    step(); chk_ack("ml_rel", 4'b0000, 2'd0);
    step(); chk_ack("ml_first", 4'b0001, 2'd0);
    chk("ml_first_ptr", 32'(dut.ptr_q), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
